// File: rtl/inst_loader_pkg.sv
// inst_loader_pkg: state encoding and word/address constants shared by the program loader
package inst_loader_pkg;
    typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, WRITE, DONE, ERROR, CSUM} state_t;
    localparam int WORD_BYTES = 4;
    localparam logic [31:0] ADDR_STEP = 32'd4;
endpackage

// File: rtl/inst_loader_word_assembler.sv
// inst_loader_word_assembler: MSB-first byte shift register that packs four stream bytes into one word
module inst_loader_word_assembler import inst_loader_pkg::*; (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  byte_in,
    input  logic        shift_en,
    input  logic        clear,
    output logic [31:0] word_out,
    output logic        word_full
);
    logic [1:0] idx;

    assign word_full = shift_en && idx == 2'(WORD_BYTES - 1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            word_out <= '0;
            idx      <= '0;
        end else if (clear) begin
            idx <= '0;
        end else if (shift_en) begin
            word_out <= {word_out[23:0], byte_in};
            idx      <= idx + 2'd1;
        end
    end
endmodule

// File: rtl/inst_loader.sv
// inst_loader: boot-time loader turning a length-prefixed big-endian byte stream into instruction memory writes.
// Define INST_LOADER_CHECKSUM_EN to require a trailing XOR-of-data-bytes checksum byte.
module inst_loader import inst_loader_pkg::*; #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        inst_memory_load_enable,
    output logic [31:0] inst_memory_write_addr,
    output logic [31:0] inst_memory_write_data,
    output logic        PC_reset,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);
    state_t      state;
    logic [15:0] cnt;
    logic [31:0] addr;
    logic [31:0] word;
    logic        word_full;
    logic        xfer;
    logic [15:0] n_hdr;
`ifdef INST_LOADER_CHECKSUM_EN
    logic [7:0]  csum;
    localparam state_t FIN = CSUM;
`else
    localparam state_t FIN = DONE;
`endif

    assign byte_ready              = state inside {HDR0, HDR1, DATA, CSUM};
    assign busy                    = byte_ready || state == WRITE;
    assign done                    = state == DONE;
    assign error                   = state == ERROR;
    assign inst_memory_load_enable = state == WRITE;
    assign inst_memory_write_addr  = addr;
    assign inst_memory_write_data  = word;
    assign xfer                    = byte_valid && byte_ready;
    assign n_hdr                   = {cnt[15:8], byte_data};

    inst_loader_word_assembler u_asm (
        .clock     (clock),
        .reset_n   (reset_n),
        .byte_in   (byte_data),
        .shift_en  (state == DATA && byte_valid),
        .clear     (state == HDR0),
        .word_out  (word),
        .word_full (word_full)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            addr         <= '0;
            words_loaded <= '0;
            PC_reset     <= 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
        end else begin
            // PC release lags DONE by one clock so the memory write settles first
            PC_reset <= state != DONE;
            case (state)
                IDLE, DONE, ERROR: if (start) begin
                    state        <= HDR0;
                    words_loaded <= '0;
                    addr         <= BASE_ADDR;
                    PC_reset     <= 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
                    csum         <= '0;
`endif
                end
                HDR0: if (xfer) begin
                    cnt[15:8] <= byte_data;
                    state     <= HDR1;
                end
                HDR1: if (xfer) begin
                    cnt[7:0] <= byte_data;
                    state    <= n_hdr == 16'd0 ? FIN : n_hdr > 16'(MAX_WORDS) ? ERROR : DATA;
                end
                DATA: if (xfer) begin
`ifdef INST_LOADER_CHECKSUM_EN
                    csum <= csum ^ byte_data;
`endif
                    if (word_full) state <= WRITE;
                end
                WRITE: begin
                    words_loaded <= words_loaded + 16'd1;
                    addr         <= addr + ADDR_STEP;
                    state        <= words_loaded + 16'd1 < cnt ? DATA : FIN;
                end
`ifdef INST_LOADER_CHECKSUM_EN
                CSUM: if (xfer) state <= byte_data == csum ? DONE : ERROR;
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: directed self-checking bench for the byte-stream program loader
module tb_inst_loader;
    logic        clock = 0;
    logic        reset_n = 0;
    logic        start = 0;
    logic        byte_valid = 0;
    logic [7:0]  byte_data = 0;
    logic        byte_ready;
    logic        inst_memory_load_enable;
    logic [31:0] inst_memory_write_addr;
    logic [31:0] inst_memory_write_data;
    logic        PC_reset;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    int compared = 0;
    int mismatched = 0;
    int ready_bad = 0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [7:0]  img[$];
`ifdef INST_LOADER_CHECKSUM_EN
    int force_trailer = -1;
`endif

    inst_loader dut (
        .clock                   (clock),
        .reset_n                 (reset_n),
        .start                   (start),
        .byte_valid              (byte_valid),
        .byte_data               (byte_data),
        .byte_ready              (byte_ready),
        .inst_memory_load_enable (inst_memory_load_enable),
        .inst_memory_write_addr  (inst_memory_write_addr),
        .inst_memory_write_data  (inst_memory_write_data),
        .PC_reset                (PC_reset),
        .busy                    (busy),
        .done                    (done),
        .error                   (error),
        .words_loaded            (words_loaded)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (inst_memory_load_enable) begin
            wr_addr.push_back(inst_memory_write_addr);
            wr_data.push_back(inst_memory_write_data);
            if (byte_ready) ready_bad++;
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit jit);
        int t = 0;
        @(negedge clock);
        if (jit) while ($urandom_range(0, 1) == 1) @(negedge clock);
        byte_valid = 1;
        byte_data  = b;
        while (!byte_ready && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (t >= 50) begin
            compared++;
            mismatched++;
            $display("FAIL byte_ready_timeout: got 0 want 1");
        end
        @(posedge clock);
        #1 byte_valid = 0;
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1;
        @(negedge clock);
        start = 0;
    endtask

    task automatic wait_end();
        int t = 0;
        do begin
            @(negedge clock);
            t++;
        end while (!(done || error) && t < 100);
        if (!(done || error)) begin
            compared++;
            mismatched++;
            $display("FAIL end_timeout: got busy=%0b want done or error", busy);
        end
    endtask

    task automatic run_load(input logic [15:0] n, input bit jit);
`ifdef INST_LOADER_CHECKSUM_EN
        logic [7:0] x = 0;
`endif
        wr_addr.delete();
        wr_data.delete();
        pulse_start();
        send_byte(n[15:8], jit);
        send_byte(n[7:0], jit);
        foreach (img[i]) begin
            send_byte(img[i], jit);
`ifdef INST_LOADER_CHECKSUM_EN
            x ^= img[i];
`endif
        end
`ifdef INST_LOADER_CHECKSUM_EN
        if (n <= 16'd256) send_byte(force_trailer < 0 ? x : 8'(force_trailer), jit);
`endif
        wait_end();
    endtask

    task automatic check_two_word_image(input string tag);
        compared++;
        if (wr_addr.size() !== 2) begin
            mismatched++;
            $display("FAIL %s_write_count: got %0d want 2", tag, wr_addr.size());
        end else begin
            compared++;
            if (wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h2001000A) begin
                mismatched++;
                $display("FAIL %s_word0: got %h@%h want 2001000a@00000000", tag, wr_data[0], wr_addr[0]);
            end
            compared++;
            if (wr_addr[1] !== 32'h4 || wr_data[1] !== 32'hAC010000) begin
                mismatched++;
                $display("FAIL %s_word1: got %h@%h want ac010000@00000004", tag, wr_data[1], wr_addr[1]);
            end
        end
        compared++;
        if (words_loaded !== 16'd2 || done !== 1'b1 || error !== 1'b0) begin
            mismatched++;
            $display("FAIL %s_status: got words=%0d done=%b error=%b want 2 1 0", tag, words_loaded, done, error);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        #1;
        compared++;
        if ({byte_ready, inst_memory_load_enable, busy, done, error} !== 5'b0 || PC_reset !== 1'b1 ||
            words_loaded !== 16'd0 || inst_memory_write_addr !== 32'h0 || inst_memory_write_data !== 32'h0) begin
            mismatched++;
            $display("FAIL reset_state: got rdy=%b le=%b busy=%b done=%b err=%b pcr=%b words=%0d addr=%h data=%h want 0 0 0 0 0 1 0 0 0",
                     byte_ready, inst_memory_load_enable, busy, done, error, PC_reset, words_loaded,
                     inst_memory_write_addr, inst_memory_write_data);
        end
        @(negedge clock);
        reset_n = 1;
    endtask

    task automatic test_basic();
        img = '{8'h20, 8'h01, 8'h00, 8'h0A, 8'hAC, 8'h01, 8'h00, 8'h00};
        run_load(16'd2, 0);
        check_two_word_image("basic");
        compared++;
        if (PC_reset !== 1'b1) begin
            mismatched++;
            $display("FAIL basic_pc_reset_first_done_cycle: got %b want 1", PC_reset);
        end
        @(negedge clock);
        compared++;
        if (PC_reset !== 1'b0 || busy !== 1'b0 || byte_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL basic_pc_release: got pcr=%b busy=%b rdy=%b want 0 0 0", PC_reset, busy, byte_ready);
        end
    endtask

    task automatic test_zero_words();
        img = {};
        run_load(16'd0, 0);
        compared++;
        if (wr_addr.size() !== 0 || words_loaded !== 16'd0 || done !== 1'b1) begin
            mismatched++;
            $display("FAIL zero_words: got writes=%0d words=%0d done=%b want 0 0 1", wr_addr.size(), words_loaded, done);
        end
    endtask

    task automatic test_overflow();
        img = {};
        run_load(16'h0101, 0);
        repeat (2) @(negedge clock);
        compared++;
        if (error !== 1'b1 || done !== 1'b0 || PC_reset !== 1'b1 || wr_addr.size() !== 0 || words_loaded !== 16'd0) begin
            mismatched++;
            $display("FAIL overflow: got err=%b done=%b pcr=%b writes=%0d words=%0d want 1 0 1 0 0",
                     error, done, PC_reset, wr_addr.size(), words_loaded);
        end
    endtask

    task automatic test_jitter();
        img = '{8'h20, 8'h01, 8'h00, 8'h0A, 8'hAC, 8'h01, 8'h00, 8'h00};
        ready_bad = 0;
        run_load(16'd2, 1);
        check_two_word_image("jitter");
        compared++;
        if (ready_bad !== 0) begin
            mismatched++;
            $display("FAIL jitter_ready_in_write: got %0d cycles want 0", ready_bad);
        end
    endtask

    task automatic test_start_ignored();
        wr_addr.delete();
        wr_data.delete();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'hDE, 0);
        send_byte(8'hAD, 0);
        pulse_start();
        send_byte(8'hBE, 0);
        send_byte(8'hEF, 0);
`ifdef INST_LOADER_CHECKSUM_EN
        send_byte(8'h22, 0);
`endif
        wait_end();
        compared++;
        if (wr_addr.size() !== 1 || wr_addr[0] !== 32'h0 || wr_data[0] !== 32'hDEADBEEF || done !== 1'b1) begin
            mismatched++;
            $display("FAIL start_ignored: got writes=%0d data=%h done=%b want 1 deadbeef 1",
                     wr_addr.size(), wr_data[0], done);
        end
    endtask

    task automatic test_max_words();
        img = {};
        for (int i = 0; i < 256; i++) begin
            img.push_back(8'(i));
            img.push_back(~8'(i));
            img.push_back(8'h5A);
            img.push_back(8'(i) ^ 8'hC3);
        end
        run_load(16'd256, 0);
        compared++;
        if (done !== 1'b1 || error !== 1'b0 || words_loaded !== 16'd256 || wr_addr.size() !== 256) begin
            mismatched++;
            $display("FAIL max_words_status: got done=%b err=%b words=%0d writes=%0d want 1 0 256 256",
                     done, error, words_loaded, wr_addr.size());
        end else begin
            compared++;
            if (wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h00FF5AC3) begin
                mismatched++;
                $display("FAIL max_words_first: got %h@%h want 00ff5ac3@00000000", wr_data[0], wr_addr[0]);
            end
            compared++;
            if (wr_addr[255] !== 32'h3FC || wr_data[255] !== 32'hFF005A3C) begin
                mismatched++;
                $display("FAIL max_words_last: got %h@%h want ff005a3c@000003fc", wr_data[255], wr_addr[255]);
            end
        end
    endtask

    task automatic test_reset_abort();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        foreach (img[i]) if (i < 5) send_byte(img[i], 0);
        @(negedge clock);
        reset_n = 0;
        #1;
        compared++;
        if (busy !== 1'b0 || PC_reset !== 1'b1 || words_loaded !== 16'd0 || inst_memory_load_enable !== 1'b0) begin
            mismatched++;
            $display("FAIL abort_state: got busy=%b pcr=%b words=%0d le=%b want 0 1 0 0",
                     busy, PC_reset, words_loaded, inst_memory_load_enable);
        end
        @(negedge clock);
        reset_n = 1;
        img = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_load(16'd1, 0);
        compared++;
        if (wr_addr.size() !== 1 || wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h11223344 || words_loaded !== 16'd1) begin
            mismatched++;
            $display("FAIL abort_reload: got writes=%0d %h@%h words=%0d want 1 11223344@00000000 1",
                     wr_addr.size(), wr_data[0], wr_addr[0], words_loaded);
        end
    endtask

`ifdef INST_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        img = '{8'h20, 8'h01, 8'h00, 8'h0A, 8'hAC, 8'h01, 8'h00, 8'h00};
        force_trailer = 8'h86;
        run_load(16'd2, 0);
        compared++;
        if (done !== 1'b1 || error !== 1'b0) begin
            mismatched++;
            $display("FAIL csum_match: got done=%b err=%b want 1 0", done, error);
        end
        force_trailer = 8'h00;
        run_load(16'd2, 0);
        @(negedge clock);
        compared++;
        if (error !== 1'b1 || done !== 1'b0 || PC_reset !== 1'b1) begin
            mismatched++;
            $display("FAIL csum_mismatch: got err=%b done=%b pcr=%b want 1 0 1", error, done, PC_reset);
        end
        force_trailer = -1;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_zero_words();
        test_overflow();
        test_jitter();
        test_start_ignored();
        test_max_words();
        test_reset_abort();
`ifdef INST_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
